// File: rtl/btb_pkg.sv
// ---------------------------------------------------------------------------
// btb_pkg
//   Shared types and helpers for the branch target buffer and its predictor
//   update unit (branch_target_buffer_fsm).
//
//   btb_pred_e           : 2-bit saturating predictor encoding.
//   BTB_PRED_INIT_*      : predictor values used when an entry is allocated.
//   BTB_PRED_REPLACE     : predictor value written on entry replacement.
//   sat_next()           : saturating next-state rule, width-agnostic up to
//                          4-bit counters; max_state bounds the counter.
// ---------------------------------------------------------------------------
package btb_pkg;

    localparam int unsigned BTB_SAT_W = 4;

    typedef enum logic [1:0] {
        STRONG_NT = 2'd0,
        WEAK_NT   = 2'd1,
        WEAK_T    = 2'd2,
        STRONG_T  = 2'd3
    } btb_pred_e;

    localparam btb_pred_e BTB_PRED_INIT_TAKEN     = STRONG_T;
    localparam btb_pred_e BTB_PRED_INIT_NOT_TAKEN = STRONG_NT;
    localparam btb_pred_e BTB_PRED_REPLACE        = WEAK_NT;

    // Saturating up/down step; the increment is widened by one bit so the
    // top state can never wrap to zero.
    function automatic logic [BTB_SAT_W-1:0] sat_next(
        input logic [BTB_SAT_W-1:0] current,
        input logic                 taken,
        input logic [BTB_SAT_W-1:0] max_state
    );
        logic [BTB_SAT_W:0] wide;
        logic [BTB_SAT_W-1:0] result;
        wide   = '0;
        result = current;
        if (taken) begin
            wide = {1'b0, current} + (BTB_SAT_W+1)'(1);
            if (wide > {1'b0, max_state}) begin
                result = max_state;
            end else begin
                result = wide[BTB_SAT_W-1:0];
            end
        end else begin
            if (current == '0) begin
                result = '0;
            end else begin
                result = current - BTB_SAT_W'(1);
            end
        end
        return result;
    endfunction

endpackage : btb_pkg

// File: rtl/branch_target_buffer_fsm.sv
// ---------------------------------------------------------------------------
// branch_target_buffer_fsm
//   Saturating-counter predictor update unit for the BTB. Takes the stored
//   predictor of the entry being written plus the resolved outcome and
//   produces the registered next predictor state (one cycle latency). Holds
//   no per-entry storage.
//
//   Parameters
//     COUNTER_WIDTH  predictor width in bits (1..4)
//     RESET_STATE    value of btb_fsm_new_prediction while in reset
//
//   Ports
//     btb_fsm_clk                 in   clock, rising edge
//     btb_fsm_reset_n             in   asynchronous active-low reset
//     btb_fsm_update              in   update qualifier (BTB write enable)
//     btb_fsm_branch_taken        in   resolved outcome, 1 = taken
//     btb_fsm_current_prediction  in   stored predictor of the entry
//     btb_fsm_new_prediction      out  registered next predictor state
//     btb_fsm_predict_taken       out  registered MSB of new_prediction
//     btb_fsm_mispredict          out  registered stored-MSB != outcome flag
//
//   Optional (macro BTB_FSM_STATS_EN)
//     btb_fsm_update_count        out  saturating count of update cycles
//     btb_fsm_mispredict_count    out  saturating count of mispredicts
// ---------------------------------------------------------------------------
module branch_target_buffer_fsm
    import btb_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 2,
    parameter int unsigned RESET_STATE   = 1
) (
    input  logic                     btb_fsm_clk,
    input  logic                     btb_fsm_reset_n,
    input  logic                     btb_fsm_update,
    input  logic                     btb_fsm_branch_taken,
    input  logic [COUNTER_WIDTH-1:0] btb_fsm_current_prediction,
    output logic [COUNTER_WIDTH-1:0] btb_fsm_new_prediction,
    output logic                     btb_fsm_predict_taken,
    output logic                     btb_fsm_mispredict
`ifdef BTB_FSM_STATS_EN
    ,
    output logic [31:0]              btb_fsm_update_count,
    output logic [31:0]              btb_fsm_mispredict_count
`endif
);

    localparam int unsigned MSB       = COUNTER_WIDTH - 1;
    localparam int unsigned MAX_STATE = (1 << COUNTER_WIDTH) - 1;

    localparam logic [COUNTER_WIDTH-1:0] RESET_PRED = COUNTER_WIDTH'(RESET_STATE);
    localparam logic [BTB_SAT_W-1:0]     MAX_PRED   = BTB_SAT_W'(MAX_STATE);

    logic [COUNTER_WIDTH-1:0] new_prediction_next;
    logic                     predict_taken_next;
    logic                     mispredict_next;
    logic [BTB_SAT_W-1:0]     sat_result;

    // Output/state registers; reset dominates any same-cycle update.
    always_ff @(posedge btb_fsm_clk or negedge btb_fsm_reset_n) begin
        if (!btb_fsm_reset_n) begin
            btb_fsm_new_prediction <= RESET_PRED;
            btb_fsm_predict_taken  <= RESET_PRED[MSB];
            btb_fsm_mispredict     <= 1'b0;
        end else begin
            btb_fsm_new_prediction <= new_prediction_next;
            btb_fsm_predict_taken  <= predict_taken_next;
            btb_fsm_mispredict     <= mispredict_next;
        end
    end

    // Next-state: saturating step on update, registered pass-through otherwise.
    always_comb begin
        sat_result          = '0;
        new_prediction_next = btb_fsm_current_prediction;
        mispredict_next     = 1'b0;

        if (btb_fsm_update) begin
            sat_result = sat_next(BTB_SAT_W'(btb_fsm_current_prediction),
                                  btb_fsm_branch_taken, MAX_PRED);
            new_prediction_next = COUNTER_WIDTH'(sat_result);
            mispredict_next     = btb_fsm_current_prediction[MSB] ^ btb_fsm_branch_taken;
        end

        predict_taken_next = new_prediction_next[MSB];
    end

`ifdef BTB_FSM_STATS_EN
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] update_count_next;
    logic [31:0] mispredict_count_next;

    // Statistics registers, cleared by reset.
    always_ff @(posedge btb_fsm_clk or negedge btb_fsm_reset_n) begin
        if (!btb_fsm_reset_n) begin
            btb_fsm_update_count     <= 32'd0;
            btb_fsm_mispredict_count <= 32'd0;
        end else begin
            btb_fsm_update_count     <= update_count_next;
            btb_fsm_mispredict_count <= mispredict_count_next;
        end
    end

    // Saturating increments; mispredicts counted on the edge that registers them.
    always_comb begin
        update_count_next     = btb_fsm_update_count;
        mispredict_count_next = btb_fsm_mispredict_count;

        if (btb_fsm_update && (btb_fsm_update_count != CNT_MAX)) begin
            update_count_next = btb_fsm_update_count + 32'd1;
        end
        if (mispredict_next && (btb_fsm_mispredict_count != CNT_MAX)) begin
            mispredict_count_next = btb_fsm_mispredict_count + 32'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule : branch_target_buffer_fsm

// File: tb/tb_branch_target_buffer_fsm.sv
// ---------------------------------------------------------------------------
// tb_branch_target_buffer_fsm
//   Self-checking bench for branch_target_buffer_fsm (COUNTER_WIDTH = 2,
//   RESET_STATE = 1). Expected outputs are pushed to a scoreboard queue when
//   inputs are driven and popped one cycle later. Define BTB_FSM_STATS_EN to
//   also exercise the statistics counters.
// ---------------------------------------------------------------------------
module tb_branch_target_buffer_fsm;

    typedef struct {
        logic [1:0] pred;
        logic       pt;
        logic       mis;
    } exp_t;

    logic       btb_fsm_clk;
    logic       btb_fsm_reset_n;
    logic       btb_fsm_update;
    logic       btb_fsm_branch_taken;
    logic [1:0] btb_fsm_current_prediction;
    logic [1:0] btb_fsm_new_prediction;
    logic       btb_fsm_predict_taken;
    logic       btb_fsm_mispredict;
`ifdef BTB_FSM_STATS_EN
    logic [31:0] btb_fsm_update_count;
    logic [31:0] btb_fsm_mispredict_count;
`endif

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    branch_target_buffer_fsm #(
        .COUNTER_WIDTH(2),
        .RESET_STATE  (1)
    ) dut (
        .btb_fsm_clk               (btb_fsm_clk),
        .btb_fsm_reset_n           (btb_fsm_reset_n),
        .btb_fsm_update            (btb_fsm_update),
        .btb_fsm_branch_taken      (btb_fsm_branch_taken),
        .btb_fsm_current_prediction(btb_fsm_current_prediction),
        .btb_fsm_new_prediction    (btb_fsm_new_prediction),
        .btb_fsm_predict_taken     (btb_fsm_predict_taken),
        .btb_fsm_mispredict        (btb_fsm_mispredict)
`ifdef BTB_FSM_STATS_EN
        ,
        .btb_fsm_update_count      (btb_fsm_update_count),
        .btb_fsm_mispredict_count  (btb_fsm_mispredict_count)
`endif
    );

    initial btb_fsm_clk = 1'b0;
    always #5 btb_fsm_clk = ~btb_fsm_clk;

    // Independent reference: 2-bit saturating counter.
    function automatic exp_t model(input logic upd, input logic tk, input logic [1:0] cur);
        exp_t e;
        e.pred = cur;
        e.mis  = 1'b0;
        if (upd) begin
            if (tk) e.pred = (cur == 2'd3) ? 2'd3 : cur + 2'd1;
            else    e.pred = (cur == 2'd0) ? 2'd0 : cur - 2'd1;
            e.mis = (cur[1] != tk);
        end
        e.pt = e.pred[1];
        return e;
    endfunction

    // Drive one vector at the falling edge, push its expectation, then
    // return just after the rising edge that registers it.
    task automatic step(input logic upd, input logic tk, input logic [1:0] cur);
        @(negedge btb_fsm_clk);
        btb_fsm_update             = upd;
        btb_fsm_branch_taken       = tk;
        btb_fsm_current_prediction = cur;
        sb.push_back(model(upd, tk, cur));
        @(posedge btb_fsm_clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        btb_fsm_reset_n            = 1'b0;
        btb_fsm_update             = 1'b0;
        btb_fsm_branch_taken       = 1'b0;
        btb_fsm_current_prediction = 2'd0;
        repeat (2) @(posedge btb_fsm_clk);
        #1;
        n_vec++;
        if (btb_fsm_new_prediction !== 2'd1 || btb_fsm_predict_taken !== 1'b0 ||
            btb_fsm_mispredict !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init: got pred=%0d pt=%b mis=%b, want pred=1 pt=0 mis=0",
                     btb_fsm_new_prediction, btb_fsm_predict_taken, btb_fsm_mispredict);
        end
        @(negedge btb_fsm_clk);
        btb_fsm_reset_n = 1'b1;
        // Move away from the reset state so the async reset is observable.
        step(1'b1, 1'b0, 2'd3);
        e = sb.pop_front();
        n_vec++;
        if (btb_fsm_new_prediction !== e.pred || btb_fsm_mispredict !== e.mis) begin
            n_fail++;
            $display("FAIL reset_pre: got pred=%0d mis=%b, want pred=%0d mis=%b",
                     btb_fsm_new_prediction, btb_fsm_mispredict, e.pred, e.mis);
        end
        // Assert reset between edges and check without any clock edge.
        #2;
        btb_fsm_reset_n = 1'b0;
        #1;
        n_vec++;
        if (btb_fsm_new_prediction !== 2'd1 || btb_fsm_predict_taken !== 1'b0 ||
            btb_fsm_mispredict !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got pred=%0d pt=%b mis=%b, want pred=1 pt=0 mis=0",
                     btb_fsm_new_prediction, btb_fsm_predict_taken, btb_fsm_mispredict);
        end
        @(negedge btb_fsm_clk);
        btb_fsm_reset_n = 1'b1;
    endtask

    task automatic test_walk(input logic tk);
        exp_t e;
        logic [1:0] cur;
        for (int i = 0; i < 4; i++) begin
            cur = tk ? 2'(i) : 2'(3 - i);
            step(1'b1, tk, cur);
            e = sb.pop_front();
            n_vec++;
            if (btb_fsm_new_prediction !== e.pred || btb_fsm_predict_taken !== e.pt ||
                btb_fsm_mispredict !== e.mis) begin
                n_fail++;
                $display("FAIL walk_t%0b cur=%0d: got pred=%0d pt=%b mis=%b, want pred=%0d pt=%b mis=%b",
                         tk, cur, btb_fsm_new_prediction, btb_fsm_predict_taken,
                         btb_fsm_mispredict, e.pred, e.pt, e.mis);
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        step(1'b1, 1'b0, 2'd2);   // leave mispredict set beforehand
        void'(sb.pop_front());
        step(1'b0, 1'b1, 2'd2);
        e = sb.pop_front();
        n_vec++;
        if (btb_fsm_new_prediction !== 2'd2 || btb_fsm_mispredict !== 1'b0 ||
            btb_fsm_predict_taken !== 1'b1 || e.pred !== 2'd2) begin
            n_fail++;
            $display("FAIL hold: got pred=%0d pt=%b mis=%b, want pred=2 pt=1 mis=0",
                     btb_fsm_new_prediction, btb_fsm_predict_taken, btb_fsm_mispredict);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        @(negedge btb_fsm_clk);
        btb_fsm_update             = 1'b1;
        btb_fsm_branch_taken       = 1'b1;
        btb_fsm_current_prediction = 2'd3;
        btb_fsm_reset_n            = 1'b0;
        @(posedge btb_fsm_clk);
        #1;
        n_vec++;
        if (btb_fsm_new_prediction !== 2'd1 || btb_fsm_predict_taken !== 1'b0 ||
            btb_fsm_mispredict !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got pred=%0d pt=%b mis=%b, want pred=1 pt=0 mis=0",
                     btb_fsm_new_prediction, btb_fsm_predict_taken, btb_fsm_mispredict);
        end
        @(negedge btb_fsm_clk);
        btb_fsm_reset_n = 1'b1;
        step(1'b1, 1'b1, 2'd3);
        e = sb.pop_front();
        n_vec++;
        if (btb_fsm_new_prediction !== e.pred || btb_fsm_predict_taken !== e.pt ||
            btb_fsm_mispredict !== e.mis) begin
            n_fail++;
            $display("FAIL reset_release: got pred=%0d pt=%b mis=%b, want pred=%0d pt=%b mis=%b",
                     btb_fsm_new_prediction, btb_fsm_predict_taken, btb_fsm_mispredict,
                     e.pred, e.pt, e.mis);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic upd;
        logic tk;
        logic [1:0] cur;
        for (int i = 0; i < 40; i++) begin
            upd = 1'($urandom_range(0, 3) != 0);
            tk  = 1'($urandom_range(0, 1));
            cur = 2'($urandom_range(0, 3));
            step(upd, tk, cur);
            e = sb.pop_front();
            n_vec++;
            if (btb_fsm_new_prediction !== e.pred || btb_fsm_predict_taken !== e.pt ||
                btb_fsm_mispredict !== e.mis) begin
                n_fail++;
                $display("FAIL b2b[%0d] upd=%b tk=%b cur=%0d: got pred=%0d pt=%b mis=%b, want pred=%0d pt=%b mis=%b",
                         i, upd, tk, cur, btb_fsm_new_prediction, btb_fsm_predict_taken,
                         btb_fsm_mispredict, e.pred, e.pt, e.mis);
            end
        end
    endtask

`ifdef BTB_FSM_STATS_EN
    task automatic test_stats();
        logic       upd_tab [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       tk_tab  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0] cur_tab [5] = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd0};
        @(negedge btb_fsm_clk);
        btb_fsm_reset_n = 1'b0;
        @(negedge btb_fsm_clk);
        btb_fsm_reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(upd_tab[i], tk_tab[i], cur_tab[i]);
            void'(sb.pop_front());
        end
        step(1'b0, 1'b1, 2'd0);
        step(1'b0, 1'b0, 2'd3);
        sb.delete();
        n_vec++;
        if (btb_fsm_update_count !== 32'd5) begin
            n_fail++;
            $display("FAIL stats_updates: got %0d, want 5", btb_fsm_update_count);
        end
        n_vec++;
        if (btb_fsm_mispredict_count !== 32'd3) begin
            n_fail++;
            $display("FAIL stats_mispredicts: got %0d, want 3", btb_fsm_mispredict_count);
        end
        #2;
        btb_fsm_reset_n = 1'b0;
        #1;
        n_vec++;
        if (btb_fsm_update_count !== 32'd0 || btb_fsm_mispredict_count !== 32'd0) begin
            n_fail++;
            $display("FAIL stats_reset: got upd=%0d mis=%0d, want 0 0",
                     btb_fsm_update_count, btb_fsm_mispredict_count);
        end
        @(negedge btb_fsm_clk);
        btb_fsm_reset_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_walk(1'b1);
        test_walk(1'b0);
        test_hold();
        test_reset_mid();
        test_back_to_back();
`ifdef BTB_FSM_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_branch_target_buffer_fsm

// File: doc/branch_target_buffer_fsm.md
Name: branch_target_buffer_fsm

Overview:
Saturating-counter branch predictor update unit used by the branch target buffer (BTB). Each cycle it takes the stored predictor state of the BTB entry being written, plus the resolved branch outcome, and produces the registered next predictor state. The BTB writes that state back into the entry on a tag-match update. Pure next-state logic plus output registers; holds no per-entry storage.

Parameters:
- COUNTER_WIDTH, 2, predictor counter width in bits. Legal range is 1..4. The state range is 0..2^COUNTER_WIDTH-1.
- RESET_STATE, 1, value loaded into btb_fsm_new_prediction on reset. Default is weak not-taken. Must be below 2^COUNTER_WIDTH.

Ports:
- btb_fsm_clk  input  1  clock; all state changes on the rising edge.
- btb_fsm_reset_n  input  1  asynchronous active-low reset.
- btb_fsm_update  input  1  update qualifier; the parent drives it from its BTB write enable.
- btb_fsm_branch_taken  input  1  resolved outcome (1 = taken).
- btb_fsm_current_prediction  input  COUNTER_WIDTH  stored predictor of the entry being updated.
- btb_fsm_new_prediction  output  COUNTER_WIDTH  registered next predictor state.
- btb_fsm_predict_taken  output  1  registered MSB of btb_fsm_new_prediction.
- btb_fsm_mispredict  output  1  registered flag: the stored prediction's MSB differed from btb_fsm_branch_taken on an update.

Behaviour:
- Reset (btb_fsm_reset_n = 0, asynchronous, takes effect immediately):
  - btb_fsm_new_prediction = RESET_STATE.
  - btb_fsm_predict_taken = RESET_STATE MSB.
  - btb_fsm_mispredict = 0.
- Release of reset is synchronous to btb_fsm_clk.
- Latency: one cycle. Inputs sampled at edge N appear on the outputs after edge N.
- With COUNTER_WIDTH = 2, states are STRONG_NT = 0, WEAK_NT = 1, WEAK_T = 2, STRONG_T = 3.
- Transitions when btb_fsm_update = 1:
  - taken: next = min(current + 1, MAX).
  - not taken: next = max(current - 1, 0).
  - Saturation: STRONG_T stays STRONG_T on taken; STRONG_NT stays STRONG_NT on not taken. No wrap-around.
  - Arithmetic must be done at COUNTER_WIDTH+1 bits, or via explicit compare, so 3 + 1 never yields 0.
- Transitions when btb_fsm_update = 0:
  - next = current (pass-through, registered).
  - btb_fsm_mispredict <= 0.
- Predicted direction is the MSB of the state: 1 = taken.
- btb_fsm_mispredict <= update & (current MSB != branch_taken).
- Inputs carrying X/unknown are not required to be handled. Combinational input-to-output paths are forbidden.
- Reset asserted mid-operation overrides any update in the same cycle.

Optional Feature:
Macro BTB_FSM_STATS_EN.
- When defined, add two outputs:
  - btb_fsm_update_count, 32 bits.
  - btb_fsm_mispredict_count, 32 bits.
- update_count increments on every edge with btb_fsm_update = 1.
- mispredict_count increments on every edge where the registered mispredict condition is true.
- Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- When not defined, these ports and counters do not exist, and the remaining behaviour is unchanged.

Decomposition:
- Shared package btb_pkg holds:
  - enum btb_pred_e {STRONG_NT, WEAK_NT, WEAK_T, STRONG_T} (2-bit).
  - localparam BTB_PRED_INIT_TAKEN = STRONG_T.
  - localparam BTB_PRED_INIT_NOT_TAKEN = STRONG_NT.
  - localparam BTB_PRED_REPLACE = WEAK_NT.
- The parent BTB also imports btb_pkg.
- No sub-module. Optionally, one function, sat_next(current, taken), lives in btb_pkg so the next-state rule can be reused by the verification model.

Test Plan:
1. Reset: assert btb_fsm_reset_n = 0 asynchronously between clock edges. Outputs go to new_prediction = 1, predict_taken = 0, mispredict = 0 without waiting for a clock edge.
2. Full walk, update = 1, taken = 1: current = 0, 1, 2, 3 gives new_prediction = 1, 2, 3, 3 one cycle later. Mispredict = 1, 1, 0, 0.
3. Full walk, update = 1, taken = 0: current = 3, 2, 1, 0 gives new_prediction = 2, 1, 0, 0. Mispredict = 1, 1, 0, 0. Predict_taken = 1, 0, 0, 0.
4. Hold: update = 0, current = 2, taken = 1 gives new_prediction = 2 and mispredict = 0.
5. Reset mid-stream: current = 3, taken = 1, update = 1, with reset_n pulled low in the same cycle. Output is 1, not 3; after release the next update gives 3.
6. With BTB_FSM_STATS_EN defined: 5 updates (3 mispredicting) then 2 idle cycles give update_count = 5 and mispredict_count = 3. Reset clears both to 0.
